fu_share_arbiter: RTL

Shares one fu_wrapper instance between N_REQ requesters, such as neighbouring PE lanes or the PEA control path.
- Round-robin arbitration; one operation in flight at a time.
- Grantee's operands and instruction latched, driven to the FU, held until the FU reports valid.
- Result returned to the grantee over a per-requester valid/ready response channel.
- Sits between requester ports and the FU inside the PE.

---
 rtl/fu_share_arbiter_pkg.sv | 22 ++
 rtl/fu_share_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fu_share_arbiter_pkg.sv
// Shared types for the FU share arbiter: FU opcode set and instruction word.
package fu_share_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_MUL    = 4'd3,
        OP_ADDPOW = 4'd4,
        OP_ADDMUL = 4'd5,
        OP_ACC    = 4'd6,
        OP_MAX    = 4'd7
    } fu_op_e;

    typedef struct packed {
        fu_op_e      op;
        logic [3:0]  count;
    } fu_instr_t;

    localparam fu_instr_t FU_INSTR_NOP = '{op: OP_NOP, count: 4'd0};

endpackage

// File: rtl/fu_share_arbiter.sv
// Round-robin arbiter sharing one FU between N_REQ requesters, one op in flight.
// Optional EXEC watchdog enabled by defining MAGE_FU_ARB_TIMEOUT_EN.
module fu_share_arbiter
    import fu_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned N_BITS         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*N_BITS-1:0]     req_a_i,
    input  logic [N_REQ*N_BITS-1:0]     req_b_i,
    input  logic [N_REQ*N_BITS-1:0]     req_const_i,
    input  fu_instr_t [N_REQ-1:0]       req_instr_i,
    output logic [N_REQ-1:0]            resp_valid_o,
    input  logic [N_REQ-1:0]            resp_ready_i,
    output logic [N_BITS-1:0]           resp_data_o,
    output logic                        resp_err_o,
    output logic [N_BITS-1:0]           fu_a_o,
    output logic [N_BITS-1:0]           fu_b_o,
    output logic [N_BITS-1:0]           fu_const_o,
    output fu_instr_t                   fu_instr_o,
    output logic                        fu_ops_valid_o,
    output logic                        fu_pea_ready_o,
    output logic [31:0]                 fu_acc_value_o,
    input  logic                        fu_valid_i,
    input  logic                        fu_ready_i,
    input  logic [N_BITS-1:0]           fu_res_i,
    output logic                        busy_o,
    output logic [$clog2(N_REQ)-1:0]    grant_id_o
);

    localparam int unsigned ID_W = $clog2(N_REQ);
`ifdef MAGE_FU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
`else
    localparam int unsigned CNT_W = 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, grant_id_q, pick_id, rr_next;
    logic               pick_found;
    int unsigned        cand;
    logic [N_BITS-1:0]  a_q, b_q, const_q, res_q;
    fu_instr_t          instr_q;
    logic [CNT_W-1:0]   exec_cnt_q;
    logic               sample_ok, fu_fire, resp_hs, timeout_hit;
`ifdef MAGE_FU_ARB_TIMEOUT_EN
    logic               err_q;
`else
    logic [31:0]        unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // First requesting index at or above rr_ptr, wrapping with explicit modulo.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % N_REQ;
            if (!pick_found && req_valid_i[ID_W'(cand)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(cand);
            end
        end
    end

    // Two-stage ops present a stale registered valid in their first EXEC cycle.
    assign sample_ok = ((instr_q.op != OP_ADDPOW) && (instr_q.op != OP_ADDMUL))
                       || (exec_cnt_q != '0);
    assign fu_fire   = (state_q == S_EXEC) && fu_valid_i && fu_ready_i && sample_ok;
    assign resp_hs   = (state_q == S_RESP) && resp_ready_i[grant_id_q];
    assign rr_next   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
`ifdef MAGE_FU_ARB_TIMEOUT_EN
    assign timeout_hit = (state_q == S_EXEC) && !fu_fire
                         && (exec_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pick_found) state_d = S_EXEC;
            S_EXEC:  if (fu_fire || timeout_hit) state_d = S_RESP;
            S_RESP:  if (resp_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o    = '0;
        resp_valid_o   = '0;
        resp_data_o    = '0;
        resp_err_o     = 1'b0;
        fu_instr_o     = FU_INSTR_NOP;
        fu_ops_valid_o = 1'b0;
        busy_o         = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) req_ready_o[pick_id] = 1'b1;
            end
            S_EXEC: begin
                fu_instr_o     = instr_q;
                fu_ops_valid_o = 1'b1;
            end
            S_RESP: begin
                resp_valid_o[grant_id_q] = 1'b1;
                resp_data_o              = res_q;
`ifdef MAGE_FU_ARB_TIMEOUT_EN
                resp_err_o               = err_q;
`endif
            end
            default: ;
        endcase
    end

    // Grant latch, execution counter, result capture and pointer update.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            const_q    <= '0;
            instr_q    <= FU_INSTR_NOP;
            res_q      <= '0;
            exec_cnt_q <= '0;
`ifdef MAGE_FU_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id_q <= pick_id;
                        a_q        <= req_a_i[32'(pick_id) * N_BITS +: N_BITS];
                        b_q        <= req_b_i[32'(pick_id) * N_BITS +: N_BITS];
                        const_q    <= req_const_i[32'(pick_id) * N_BITS +: N_BITS];
                        instr_q    <= req_instr_i[pick_id];
                        exec_cnt_q <= '0;
`ifdef MAGE_FU_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                S_EXEC: begin
                    if (exec_cnt_q != '1) exec_cnt_q <= exec_cnt_q + CNT_W'(1);
                    if (fu_fire) begin
                        res_q <= fu_res_i;
                    end else if (timeout_hit) begin
                        res_q <= '0;
`ifdef MAGE_FU_ARB_TIMEOUT_EN
                        err_q <= 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (resp_hs) rr_ptr_q <= rr_next;
                end
                default: ;
            endcase
        end
    end

    assign fu_a_o         = a_q;
    assign fu_b_o         = b_q;
    assign fu_const_o     = const_q;
    assign fu_pea_ready_o = 1'b1;
    assign fu_acc_value_o = '0;
    assign grant_id_o     = grant_id_q;

endmodule
